uc_multiciclo: RTL
==================

UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 Parameter EXT_BRANCH, default 1: 1 = all six RV32I branches supported; 0 = only beq/bne, other branch f3 values trap.
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  7  instruction opcode from instruction register.
REQ-005 f3  input  3  funct3 field.
REQ-006 f7  input  7  funct7 field; only bit 5 is used.
REQ-007 zero / lt / ltu  input  1 each  ALU flags: result zero, signed less-than, unsigned less-than (A vs B).
REQ-008 pcWrite  output  1  PC register enable.
REQ-009 adrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 memWrite / irWrite / regWrite  output  1 each  memory, instruction-register and register-file write enables.
REQ-011 resultSrc  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result, 11 = immExt.
REQ-012 aluSrcA  output  2  00 = PC, 01 = oldPC, 10 = rs1.
REQ-013 aluSrcB  output  2  00 = rs2, 01 = immExt, 10 = constant 4.
REQ-014 immSrc  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
REQ-015 aluControl  output  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-016 illegal  output  1  sticky illegal-instruction flag; state  output  4  current FSM state.

Function
REQ-017 Outputs shall be Moore-decoded from the state register; immSrc and aluControl additionally decode from op/f3/f7.
REQ-018 immSrc shall depend only on op, valid in every state: lw/jalr/I-type I, sw S, branch B, jal J, lui/auipc U, others 000.
REQ-019 Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
REQ-020 FETCH: adrSrc=0, irWrite=1, A=00, B=10, aluOp=add, resultSrc=10, pcWrite=1; next DECODE.
REQ-021 DECODE: A=01, B=01, aluOp=add (branch/jal target into ALUOut); next by op: lw/sw MEMADR, R EXECR, I EXECI, branch BRANCH, jal JAL, jalr JALR_ADR, lui LUI, auipc AUIPC, anything else TRAP.
REQ-022 DECODE shall also go to TRAP for a branch with f3 = 010/011, and, when EXT_BRANCH = 0, for f3 = 100-111.
REQ-023 MEMADR: A=10, B=01, add; next MEMREAD (lw) or MEMWRITE (sw). MEMREAD: adrSrc=1; next MEMWB. MEMWB: resultSrc=01, regWrite=1; next FETCH. MEMWRITE: adrSrc=1, memWrite=1; next FETCH.
REQ-024 EXECR: A=10, B=00, aluOp=funct. EXECI: A=10, B=01, aluOp=funct. Both go to ALUWB. ALUWB: resultSrc=00, regWrite=1; next FETCH.
REQ-025 BRANCH: A=10, B=00, sub, resultSrc=00; pcWrite = taken (beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu); next FETCH.
REQ-026 JAL: A=01, B=10, add, resultSrc=00, pcWrite=1; next ALUWB, which writes rd = oldPC+4.
REQ-027 JALR_ADR: A=10, B=01, add; next JALR_PC. JALR_PC: A=01, B=10, add, resultSrc=00, pcWrite=1; next ALUWB.
REQ-028 LUI: resultSrc=11, regWrite=1; next FETCH. AUIPC: A=01, B=01, add; next ALUWB.
REQ-029 aluControl: aluOp add -> 000; sub -> 001; funct -> from f3 (000 add, or sub when R-type and f7[5]=1; 010 slt; 110 or; 111 and; other f3 -> 000).
REQ-030 TRAP: all enables 0, illegal=1; no exit except reset.
REQ-031 Enables not listed for a state shall be 0; don't-care selects shall drive 0.
REQ-032 Cycles per instruction: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3, auipc 4.

Reset
REQ-033 rst_n low shall force state FETCH and clear illegal immediately, independent of clk.
REQ-034 While rst_n is low, pcWrite, irWrite, memWrite and regWrite shall be 0; FETCH begins on the first rising edge after release.
REQ-035 Reset asserted mid-instruction shall abandon that instruction with no further write enable.

Structure
REQ-036 State encoding, opcode constants, aluOp and select encodings shall live in the shared package uc_pkg.
REQ-037 aluControl decoding shall be a single sub-module, alu_deco, driven by op, f7, f3 and aluOp.

Verification
REQ-038 Reset, then lw (op 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regWrite=1 only in MEMWB with resultSrc=01.
REQ-039 bne with zero=0, then with zero=1: BRANCH pcWrite=1, then 0; aluControl=001 both times.
REQ-040 EXT_BRANCH=0, branch f3=100 -> TRAP after DECODE; illegal=1 and stays high 10 cycles; rst_n low clears it.
REQ-041 jalr: 5 cycles; pcWrite=1 in FETCH and JALR_PC; regWrite=1 only in ALUWB with resultSrc=00.
REQ-042 R-type f3=000, f7=0100000 in EXECR -> aluControl=001; lui -> 3 cycles, immSrc=100, resultSrc=11.
REQ-043 rst_n dropped in MEMWRITE, away from a clock edge -> state=FETCH and memWrite=0 in the same cycle.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings and per-state decode for the multicycle RV32I control unit.
// State codes, opcodes, ALU-op classes and mux-select values all live here.
package uc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_JALR_PC  = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } stateT;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOpT;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       pcWrite;
        logic       adrSrc;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        aluOpT      aluOp;
        logic       illegal;
    } ctrlT;

    // Branch f3 values 010/011 never exist; 1xx exist only with the extended set.
    function automatic logic branchLegal(logic [2:0] f3, logic extBranch);
        return (f3[2:1] != 2'b01) && (extBranch || !f3[2]);
    endfunction

    function automatic logic branchTaken(logic [2:0] f3, logic zero, logic lt,
                                         logic ltu, logic extBranch);
        logic t;
        t = 1'b0;
        case (f3)
            3'b000:  t = zero;
            3'b001:  t = !zero;
            3'b100:  t = extBranch && lt;
            3'b101:  t = extBranch && !lt;
            3'b110:  t = extBranch && ltu;
            3'b111:  t = extBranch && !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic stateT nextState(stateT s, logic [6:0] op, logic [2:0] f3,
                                        logic extBranch);
        stateT n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_R:         n = S_EXECR;
                    OP_I:         n = S_EXECI;
                    OP_BRANCH:    n = branchLegal(f3, extBranch) ? S_BRANCH : S_TRAP;
                    OP_JAL:       n = S_JAL;
                    OP_JALR:      n = S_JALR_ADR;
                    OP_LUI:       n = S_LUI;
                    OP_AUIPC:     n = S_AUIPC;
                    default:      n = S_TRAP;
                endcase
            end
            S_MEMADR:   n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  n = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL, S_JALR_PC, S_AUIPC: n = S_ALUWB;
            S_JALR_ADR: n = S_JALR_PC;
            S_TRAP:     n = S_TRAP;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    // Moore outputs of a state; the branch-taken pcWrite is added at the top.
    function automatic ctrlT ctrlFor(stateT s);
        ctrlT c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irWrite = 1'b1; c.pcWrite = 1'b1; c.resultSrc = RES_ALU;
                c.aluSrcA = SRCA_PC; c.aluSrcB = SRCB_FOUR;
            end
            S_DECODE:   begin c.aluSrcA = SRCA_OLDPC; c.aluSrcB = SRCB_IMM; end
            S_MEMADR:   begin c.aluSrcA = SRCA_RS1;   c.aluSrcB = SRCB_IMM; end
            S_MEMREAD:  c.adrSrc = 1'b1;
            S_MEMWB:    begin c.resultSrc = RES_MEM; c.regWrite = 1'b1; end
            S_MEMWRITE: begin c.adrSrc = 1'b1; c.memWrite = 1'b1; end
            S_EXECR: begin
                c.aluSrcA = SRCA_RS1; c.aluSrcB = SRCB_RS2; c.aluOp = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.aluSrcA = SRCA_RS1; c.aluSrcB = SRCB_IMM; c.aluOp = ALUOP_FUNCT;
            end
            S_ALUWB:    begin c.resultSrc = RES_ALUOUT; c.regWrite = 1'b1; end
            S_BRANCH: begin
                c.aluSrcA = SRCA_RS1; c.aluSrcB = SRCB_RS2; c.aluOp = ALUOP_SUB;
            end
            S_JAL, S_JALR_PC: begin
                c.aluSrcA = SRCA_OLDPC; c.aluSrcB = SRCB_FOUR; c.pcWrite = 1'b1;
            end
            S_JALR_ADR: begin c.aluSrcA = SRCA_RS1;   c.aluSrcB = SRCB_IMM; end
            S_LUI:      begin c.resultSrc = RES_IMM; c.regWrite = 1'b1; end
            S_AUIPC:    begin c.aluSrcA = SRCA_OLDPC; c.aluSrcB = SRCB_IMM; end
            S_TRAP:     c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_deco.sv
// ALU control decode: turns the FSM's ALU-op class plus funct fields into
// the 3-bit ALU operation code.
module alu_deco
    import uc_pkg::*;
(
    input  logic [6:0] op,
    input  logic [6:0] f7,
    input  logic [2:0] f3,
    input  logic [1:0] aluOp,
    output logic [2:0] aluControl
);

    logic unusedF7Bits;
    assign unusedF7Bits = ^{f7[6], f7[4:0]};

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (f3)
                    // I-type addi has no sub form, so f7[5] only matters for R-type.
                    3'b000:  aluControl = (op == OP_R && f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle RV32I control unit: one state register with registered Moore
// outputs, plus op-driven immSrc and funct-driven aluControl.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int EXT_BRANCH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] immSrc,
    output logic [2:0] aluControl,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic extBranch = (EXT_BRANCH != 0);

    stateT stateQ;
    stateT stateNext;
    ctrlT  ctrlQ;
    logic  running;

    always_comb begin
        stateNext = nextState(stateQ, op, f3, extBranch);
    end

    // Reset parks the FSM in FETCH with every enable low; the first edge after
    // release loads FETCH's outputs so FETCH then runs a full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= S_FETCH;
            ctrlQ   <= '0;
            running <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
            ctrlQ   <= ctrlFor(S_FETCH);
        end else begin
            stateQ <= stateNext;
            ctrlQ  <= ctrlFor(stateNext);
        end
    end

    // Branch outcome uses the live ALU flags of the BRANCH cycle itself.
    assign pcWrite = ctrlQ.pcWrite |
                     ((stateQ == S_BRANCH) && branchTaken(f3, zero, lt, ltu, extBranch));

    assign adrSrc    = ctrlQ.adrSrc;
    assign memWrite  = ctrlQ.memWrite;
    assign irWrite   = ctrlQ.irWrite;
    assign regWrite  = ctrlQ.regWrite;
    assign resultSrc = ctrlQ.resultSrc;
    assign aluSrcA   = ctrlQ.aluSrcA;
    assign aluSrcB   = ctrlQ.aluSrcB;
    assign illegal   = ctrlQ.illegal;
    assign state     = stateQ;

    always_comb begin
        immSrc = IMM_I;
        case (op)
            OP_LW, OP_JALR, OP_I: immSrc = IMM_I;
            OP_SW:                immSrc = IMM_S;
            OP_BRANCH:            immSrc = IMM_B;
            OP_JAL:               immSrc = IMM_J;
            OP_LUI, OP_AUIPC:     immSrc = IMM_U;
            default:              immSrc = IMM_I;
        endcase
    end

    alu_deco u_aluDeco (
        .op         (op),
        .f7         (f7),
        .f3         (f3),
        .aluOp      (ctrlQ.aluOp),
        .aluControl (aluControl)
    );

endmodule
